// File: rtl/operand_debounce.sv
// operand_debounce
//   Front end for the 2-bit greater-than comparator on the prototyping board.
//   Raw switch/pushbutton levels are brought into the clk domain through a
//   two-flop synchronizer, then debounced as a single word: the synchronized
//   value must hold unchanged for CNT_MAX consecutive timing cycles before it
//   is committed to db. Any bit change restarts timing for the whole word.
//
//   Optional feature macro: OPERAND_DEBOUNCE_GT_FLAG_EN
//     When defined, adds registered output agtb = (a > b) unsigned, updated on
//     the same edge as db so it stays aligned with a and b.
//
// Parameters
//   W        total switch bits (even); upper half = operand a, lower half = b
//   CNT_MAX  stable cycles required before commit (>= 2)
//   CNT_W    counter width, 2**CNT_W > CNT_MAX
//
// Ports
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   sw       raw asynchronous switch levels (W bits)
//   db       debounced switch word (W bits, registered)
//   a        db[W-1:W/2], straight wiring
//   b        db[W/2-1:0], straight wiring
//   db_tick  one-cycle pulse on the cycle db takes a new value
//   busy     high while a candidate value is being timed
//   agtb     (macro only) registered a > b flag of the committed word

module operand_debounce #(
  parameter int W       = 4,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   sw,
  output logic [W-1:0]   db,
  output logic [W/2-1:0] a,
  output logic [W/2-1:0] b,
  output logic           db_tick,
  output logic           busy
`ifdef OPERAND_DEBOUNCE_GT_FLAG_EN
  ,
  output logic           agtb
`endif
);

  typedef enum logic {
    STABLE = 1'b0,
    WAIT   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  state_t           state;
  state_t           state_next;

  logic [W-1:0]     sync_ff1;
  logic [W-1:0]     raw_s;

  logic [W-1:0]     cand;
  logic [W-1:0]     cand_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [W-1:0]     db_next;
  logic             tick_next;

  // Two-flop synchronizer; nothing else looks at sw.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff1 <= '0;
      raw_s    <= '0;
    end else begin
      sync_ff1 <= sw;
      raw_s    <= sync_ff1;
    end
  end

  // State and datapath registers. busy is registered from the next state so
  // it rises on the same edge the FSM enters WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= STABLE;
      cand    <= '0;
      cnt     <= '0;
      db      <= '0;
      db_tick <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cand    <= cand_next;
      cnt     <= cnt_next;
      db      <= db_next;
      db_tick <= tick_next;
      busy    <= (state_next == WAIT);
    end
  end

  // Next-state and datapath decisions. In WAIT, the bounce-back test comes
  // first; a new glitch value restarts timing; otherwise the counter advances
  // until CNT_LAST, at which point the candidate is committed.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    db_next    = db;
    tick_next  = 1'b0;
    case (state)
      STABLE: begin
        if (raw_s != db) begin
          cand_next  = raw_s;
          cnt_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (raw_s == db) begin
          cnt_next   = '0;
          state_next = STABLE;
        end else if (raw_s != cand) begin
          cand_next = raw_s;
          cnt_next  = '0;
        end else if (cnt == CNT_LAST) begin
          db_next    = cand;
          tick_next  = 1'b1;
          cnt_next   = '0;
          state_next = STABLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = STABLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef OPERAND_DEBOUNCE_GT_FLAG_EN
  // Flag is computed from the candidate on the commit edge, so it lands on
  // the same edge as db.
  always_ff @(posedge clk) begin
    if (reset) begin
      agtb <= 1'b0;
    end else if (tick_next) begin
      agtb <= (cand[W-1:W/2] > cand[W/2-1:0]);
    end
  end
`endif

  assign a = db[W-1:W/2];
  assign b = db[W/2-1:0];

  // Invariants of the timing scheme.
  a_tick_single : assert property (@(posedge clk) disable iff (reset)
    db_tick |=> !db_tick);
  a_cnt_bound : assert property (@(posedge clk) disable iff (reset)
    cnt <= CNT_LAST);
  a_busy_state : assert property (@(posedge clk) disable iff (reset)
    busy == (state == WAIT));

endmodule

// File: tb/tb_operand_debounce.sv
// Testbench for operand_debounce (W=4, CNT_MAX=4, CNT_W=3).
// Reference model: a committed word changes only after the synchronized input
// has shown the same non-db value for CNT_MAX+1 consecutive samples; the
// synchronized input is the raw input delayed by two clocks.

module tb_operand_debounce;

  localparam int W       = 4;
  localparam int CNT_MAX = 4;
  localparam int CNT_W   = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   sw;
  logic [W-1:0]   db;
  logic [W/2-1:0] a;
  logic [W/2-1:0] b;
  logic           db_tick;
  logic           busy;
`ifdef OPERAND_DEBOUNCE_GT_FLAG_EN
  logic           agtb;
`endif

  operand_debounce #(
    .W      (W),
    .CNT_MAX(CNT_MAX),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .db     (db),
    .a      (a),
    .b      (b),
    .db_tick(db_tick),
    .busy   (busy)
`ifdef OPERAND_DEBOUNCE_GT_FLAG_EN
    ,
    .agtb   (agtb)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tick_seen = 0;

  // Reference model state
  logic [W-1:0] m_s1 = '0;
  logic [W-1:0] m_s2 = '0;
  logic [W-1:0] m_prev = '0;
  logic [W-1:0] m_db = '0;
  logic         m_tick = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_gt = 1'b0;
  int           m_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic step();
    logic [W-1:0] raw;
    @(posedge clk);
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_db = '0;
      m_tick = 1'b0; m_busy = 1'b0; m_gt = 1'b0; m_run = 0;
    end else begin
      raw    = m_s2;
      m_s2   = m_s1;
      m_s1   = sw;
      m_tick = 1'b0;
      if (raw == m_db)       m_run = 0;
      else if (raw == m_prev) m_run = m_run + 1;
      else                   m_run = 1;
      if (m_run == CNT_MAX + 1) begin
        m_db   = raw;
        m_tick = 1'b1;
        m_gt   = (raw[W-1:W/2] > raw[W/2-1:0]);
        m_run  = 0;
      end
      m_busy = (raw != m_db);
      m_prev = raw;
    end
    @(negedge clk);
    check("db", 32'(db), 32'(m_db));
    check("db_tick", 32'(db_tick), 32'(m_tick));
    check("busy", 32'(busy), 32'(m_busy));
    check("a", 32'(a), 32'(m_db[W-1:W/2]));
    check("b", 32'(b), 32'(m_db[W/2-1:0]));
`ifdef OPERAND_DEBOUNCE_GT_FLAG_EN
    check("agtb", 32'(agtb), 32'(m_gt));
`endif
    if (db_tick) tick_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    sw    = 4'b1011;

    // Reset held 3 cycles, then released with 1011 on the switches
    run(3);
    check("rst_db", 32'(db), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick_seen = 0;
    run(6);
    check("rel_e6_db", 32'(db), 32'h0);
    run(1);
    check("rel_e7_db", 32'(db), 32'hB);
    check("rel_e7_tick", 32'(db_tick), 32'h1);
    check("rel_ticks", tick_seen, 32'd1);

    // Clean step 0000 -> 1101
    sw = 4'b0000; run(10);
    sw = 4'b1101;
    run(2);
    check("step_e2_busy", 32'(busy), 32'h0);
    run(1);
    check("step_e3_busy", 32'(busy), 32'h1);
    run(3);
    check("step_e6_db", 32'(db), 32'h0);
    run(1);
    check("step_e7_db", 32'(db), 32'hD);
    check("step_e7_tick", 32'(db_tick), 32'h1);
    run(1);
    check("step_e8_tick", 32'(db_tick), 32'h0);

    // Bounce 0000/0100 every 2 cycles, then hold 0100
    sw = 4'b0000; run(10);
    tick_seen = 0;
    for (int i = 0; i < 6; i++) begin
      sw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      run(2);
    end
    check("bounce_ticks", tick_seen, 32'd0);
    check("bounce_db", 32'(db), 32'h0);
    sw = 4'b0100;
    run(6);
    check("bounce_e6_db", 32'(db), 32'h0);
    run(1);
    check("bounce_e7_db", 32'(db), 32'h4);

    // Bounce back to the committed value
    sw = 4'b0000; run(10);
    tick_seen = 0;
    sw = 4'b0001; run(3);
    sw = 4'b0000; run(8);
    check("back_db", 32'(db), 32'h0);
    check("back_ticks", tick_seen, 32'd0);
    check("back_busy", 32'(busy), 32'h0);

    // Glitch to a third value
    sw = 4'b0011; run(10);
    sw = 4'b0110; run(2);
    sw = 4'b1001;
    run(6);
    check("glitch_e6_db", 32'(db), 32'h3);
    run(1);
    check("glitch_e7_db", 32'(db), 32'h9);

    // Reset mid-WAIT with 1111 held
    sw = 4'b0000; run(10);
    sw = 4'b1111; run(5);
    check("midwait_busy", 32'(busy), 32'h1);
    reset = 1'b1; run(1);
    check("midwait_rst_db", 32'(db), 32'h0);
    check("midwait_rst_tick", 32'(db_tick), 32'h0);
    reset = 1'b0;
    tick_seen = 0;
    run(6);
    check("midwait_e6_db", 32'(db), 32'h0);
    run(1);
    check("midwait_e7_db", 32'(db), 32'hF);
    check("midwait_ticks", tick_seen, 32'd1);

    // Reset on the commit edge: reset wins
    sw = 4'b0000; run(10);
    sw = 4'b0110; run(6);
    reset = 1'b1; run(1);
    check("rst_commit_db", 32'(db), 32'h0);
    check("rst_commit_tick", 32'(db_tick), 32'h0);
    reset = 1'b0;

    // Randomized segments
    for (int s = 0; s < 400; s++) begin
      sw    = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 24) == 0);
      run(1);
      reset = 1'b0;
      run(int'($urandom_range(0, 9)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
